// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between fetch and data paths, data first,
//            with a bound on fetch starvation and a ready timeout.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_ack,
    output logic              o_bus_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready
);

    localparam int                 c_RUN_W    = $clog2(MAX_DATA_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(MAX_DATA_RUN);
    localparam logic [7:0]         c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_F = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic [7:0]         r_tmo_cnt;

    logic               w_starve;
    logic               w_grant_d;
    logic [c_RUN_W-1:0] w_run_nxt;

    // A pending fetch that has already waited out MAX_DATA_RUN data grants wins.
    assign w_starve  = i_if_req && (r_run_cnt == c_RUN_MAX);
    assign w_grant_d = i_d_req && !w_starve;

    always_comb begin
        w_run_nxt = '0;
        if (i_if_req) begin
            w_run_nxt = (r_run_cnt == c_RUN_MAX) ? c_RUN_MAX : r_run_cnt + c_RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_run_cnt   <= '0;
            r_tmo_cnt   <= '0;
            o_if_rdata  <= '0;
            o_if_ack    <= 1'b0;
            o_d_rdata   <= '0;
            o_d_ack     <= 1'b0;
            o_bus_err   <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_if_ack  <= 1'b0;
            o_d_ack   <= 1'b0;
            o_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_we    <= i_d_we;
                        o_mem_en    <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_run_cnt   <= w_run_nxt;
                        r_state     <= S_BUSY_D;
                    end else if (i_if_req) begin
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_we    <= 1'b0;
                        o_mem_en    <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_run_cnt   <= '0;
                        r_state     <= S_BUSY_F;
                    end
                end
                S_BUSY_F, S_BUSY_D: begin
                    if (i_mem_ready) begin
                        o_mem_en <= 1'b0;
                        o_mem_we <= 1'b0;
                        r_state  <= S_IDLE;
                        if (r_state == S_BUSY_F) begin
                            o_if_rdata <= i_mem_rdata;
                            o_if_ack   <= 1'b1;
                        end else begin
                            if (!o_mem_we) begin
                                o_d_rdata <= i_mem_rdata;
                            end
                            o_d_ack <= 1'b1;
                        end
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        // Abort: owner sees all-ones data flagged by bus_err.
                        o_mem_en  <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_bus_err <= 1'b1;
                        r_state   <= S_IDLE;
                        if (r_state == S_BUSY_F) begin
                            o_if_rdata <= '1;
                            o_if_ack   <= 1'b1;
                        end else begin
                            o_d_rdata <= '1;
                            o_d_ack   <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
